nxs_multicore_dispatch: RTL and testbench

//  Parametrised work dispatcher and result collector for NUM_CORES Nexus hash cores.
//  - Distributes one latched work unit (block-header remainder plus midstate) to all cores.
//  - Gives each core a disjoint nonce start and pulses its active-low reset on every new work.
//  - Arbitrates found nonces into a FIFO, read by the UART TX path over a valid/ready handshake.
//  - Sits between the serial RX/TX blocks and the core array; replaces single-core glue in the top.

---
 rtl/nxs_multicore_dispatch.sv | 168 ++++++++++++++++
 tb/tb_nxs_multicore_dispatch.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/nxs_multicore_dispatch.sv
// Work broadcast + per-core nonce slots + round-robin result FIFO (found->res_valid: 2 cycles).
// Backpressure: res_ready stalls FIFO; full FIFO leaves results pending, a second find on a held slot is dropped and counted.
module nxs_multicore_dispatch #(
  parameter int NUM_CORES   = 4,
  parameter int WORK_WIDTH  = 1728,
  parameter int NONCE_WIDTH = 64,
  parameter int CORE_SHIFT  = 60,
  parameter int FIFO_DEPTH  = 8,
  parameter int RST_CYCLES  = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [WORK_WIDTH-1:0]            work_in,
  input  logic                             work_valid,
  output logic [WORK_WIDTH-1:0]            core_work,
  output logic [NUM_CORES*NONCE_WIDTH-1:0] core_start_nonce,
  output logic [NUM_CORES-1:0]             core_nrst,
  input  logic [NUM_CORES-1:0]             core_found,
  input  logic [NUM_CORES*NONCE_WIDTH-1:0] core_nonce,
  output logic                             res_valid,
  output logic [NONCE_WIDTH-1:0]           res_nonce,
  input  logic                             res_ready,
  output logic                             work_active,
  output logic [15:0]                      drop_count
);

  localparam int RR_W  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int LC_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [LC_W-1:0]        lcnt_q, lcnt_d;
  logic [WORK_WIDTH-1:0]  work_q;
  logic [NUM_CORES-1:0]   pend_q, pend_d;
  logic [NONCE_WIDTH-1:0] pnonce_q [NUM_CORES];
  logic [NONCE_WIDTH-1:0] pnonce_d [NUM_CORES];
  logic [RR_W-1:0]        rr_q, rr_d;
  logic [NONCE_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [15:0]            drop_q, drop_d;

  logic                   full, push, pop;
  logic                   have_hi, have_lo;
  logic [RR_W-1:0]        win_hi, win_lo, win;
  logic [NUM_CORES-1:0]   gnt, cap;
  logic [16:0]            drop_sum;

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_start
    assign core_start_nonce[g*NONCE_WIDTH +: NONCE_WIDTH] = NONCE_WIDTH'(g) << CORE_SHIFT;
  end

  assign core_work   = work_q;
  assign core_nrst   = {NUM_CORES{state_q == S_RUN}};
  assign work_active = (state_q == S_RUN);
  assign drop_count  = drop_q;
  assign res_valid   = (cnt_q != '0);
  assign res_nonce   = res_valid ? mem_q[rd_q] : '0;

  always_comb begin
    state_d = state_q;
    lcnt_d  = lcnt_q;
    if (work_valid) begin
      state_d = S_LOAD;
      lcnt_d  = '0;
    end else if (state_q == S_LOAD) begin
      if (lcnt_q == LC_W'(RST_CYCLES - 1)) state_d = S_RUN;
      else                                 lcnt_d  = lcnt_q + LC_W'(1);
    end
  end

  // Round-robin: lowest pending index at/after rr, else lowest pending overall.
  always_comb begin
    have_hi = 1'b0;
    have_lo = 1'b0;
    win_hi  = '0;
    win_lo  = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        have_lo = 1'b1;
        win_lo  = RR_W'(i);
        if (RR_W'(i) >= rr_q) begin
          have_hi = 1'b1;
          win_hi  = RR_W'(i);
        end
      end
    end
    win = have_hi ? win_hi : win_lo;
  end

  assign full = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign push = have_lo && !full && !work_valid;
  assign pop  = res_valid && res_ready && !work_valid;
  assign gnt  = push ? (NUM_CORES'(1) << win) : '0;
  assign cap  = (state_q == S_RUN && !work_valid) ? core_found : '0;

  // A slot drained this cycle may take a new nonce without counting a drop.
  always_comb begin
    drop_sum = {1'b0, drop_q};
    for (int i = 0; i < NUM_CORES; i++) begin
      pend_d[i]   = pend_q[i] & ~gnt[i];
      pnonce_d[i] = pnonce_q[i];
      if (cap[i]) begin
        if (pend_q[i] && !gnt[i]) begin
          drop_sum = drop_sum + 17'd1;
        end else begin
          pend_d[i]   = 1'b1;
          pnonce_d[i] = core_nonce[i*NONCE_WIDTH +: NONCE_WIDTH];
        end
      end
    end
    if (work_valid) pend_d = '0;
    drop_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_comb begin
    rr_d  = rr_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    if (push) begin
      rr_d = (win == RR_W'(NUM_CORES - 1)) ? '0 : win + RR_W'(1);
      wr_d = (wr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_q + PTR_W'(1);
    end
    if (pop) rd_d = (rd_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_q + PTR_W'(1);
    if (work_valid) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      lcnt_q  <= '0;
      work_q  <= '0;
      pend_q  <= '0;
      rr_q    <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      drop_q  <= '0;
      for (int i = 0; i < NUM_CORES; i++) pnonce_q[i] <= '0;
    end else begin
      state_q <= state_d;
      lcnt_q  <= lcnt_d;
      if (work_valid) work_q <= work_in;
      pend_q  <= pend_d;
      rr_q    <= rr_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
      for (int i = 0; i < NUM_CORES; i++) pnonce_q[i] <= pnonce_d[i];
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= pnonce_q[win];
  end

endmodule

// File: tb/tb_nxs_multicore_dispatch.sv
// Bench for nxs_multicore_dispatch: queue-based reference model checked every cycle, plus directed literal checks.
module tb_nxs_multicore_dispatch;

  localparam int N     = 4;
  localparam int W     = 1728;
  localparam int NW    = 64;
  localparam int SHIFT = 60;
  localparam int DEPTH = 8;
  localparam int RSTC  = 4;

  logic            clk = 1'b0;
  logic            rst, work_valid, res_ready;
  logic [W-1:0]    work_in;
  logic [N-1:0]    core_found;
  logic [N*NW-1:0] core_nonce;
  logic [W-1:0]    core_work;
  logic [N*NW-1:0] core_start_nonce;
  logic [N-1:0]    core_nrst;
  logic            res_valid, work_active;
  logic [NW-1:0]   res_nonce;
  logic [15:0]     drop_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nxs_multicore_dispatch #(
    .NUM_CORES(N), .WORK_WIDTH(W), .NONCE_WIDTH(NW), .CORE_SHIFT(SHIFT),
    .FIFO_DEPTH(DEPTH), .RST_CYCLES(RSTC)
  ) dut (
    .clk(clk), .rst(rst), .work_in(work_in), .work_valid(work_valid),
    .core_work(core_work), .core_start_nonce(core_start_nonce), .core_nrst(core_nrst),
    .core_found(core_found), .core_nonce(core_nonce), .res_valid(res_valid),
    .res_nonce(res_nonce), .res_ready(res_ready), .work_active(work_active),
    .drop_count(drop_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: cycles-since-work decides run phase; FIFO is a queue.
  bit          chk_en = 1'b0;
  bit          m_loaded;
  int          m_since;
  logic [W-1:0] m_work;
  bit          m_pend [N];
  bit          m_old  [N];
  logic [63:0] m_pn   [N];
  int          m_rr, m_drop, m_win;
  bit          m_run, m_full;
  logic [63:0] m_q [$];

  always @(posedge clk) begin
    if (rst) begin
      chk_en = 1'b1; m_loaded = 1'b0; m_since = 0; m_work = '0;
      m_rr = 0; m_drop = 0; m_q.delete();
      for (int i = 0; i < N; i++) begin m_pend[i] = 1'b0; m_pn[i] = '0; end
    end else if (work_valid) begin
      m_work = work_in; m_loaded = 1'b1; m_since = 0; m_q.delete();
      for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
    end else begin
      m_run = m_loaded && (m_since >= RSTC);
      if (m_loaded && m_since < 1000) m_since++;
      m_full = (m_q.size() >= DEPTH);
      m_old = m_pend;
      m_win = -1;
      if (!m_full)
        for (int k = 0; k < N; k++)
          if (m_win < 0 && m_pend[(m_rr + k) % N]) m_win = (m_rr + k) % N;
      if (m_q.size() > 0 && res_ready) void'(m_q.pop_front());
      if (m_win >= 0) begin
        m_q.push_back(m_pn[m_win]);
        m_pend[m_win] = 1'b0;
        m_rr = (m_win + 1) % N;
      end
      if (m_run)
        for (int i = 0; i < N; i++)
          if (core_found[i]) begin
            if (m_old[i] && i != m_win) begin
              if (m_drop < 65535) m_drop++;
            end else begin
              m_pend[i] = 1'b1;
              m_pn[i] = core_nonce[i*NW +: NW];
            end
          end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("core_work_lo", core_work[63:0], m_work[63:0]);
      check("core_work_full", 64'(core_work === m_work), 64'd1);
      check("core_nrst", 64'(core_nrst), (m_loaded && m_since >= RSTC) ? 64'hF : 64'h0);
      check("work_active", 64'(work_active), 64'(m_loaded && m_since >= RSTC));
      check("res_valid", 64'(res_valid), 64'(m_q.size() > 0));
      check("res_nonce", res_nonce, (m_q.size() > 0) ? m_q[0] : 64'h0);
      check("drop_count", 64'(drop_count), 64'(m_drop));
      for (int i = 0; i < N; i++)
        check("start_nonce", core_start_nonce[i*NW +: NW], 64'(i) << SHIFT);
    end
  end

  initial begin
    rst = 1'b1; work_valid = 1'b0; res_ready = 1'b0;
    work_in = '0; core_found = '0; core_nonce = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_nrst", 64'(core_nrst), 64'h0);
    check("rst_active", 64'(work_active), 64'h0);
    check("rst_valid", 64'(res_valid), 64'h0);
    check("rst_nonce", res_nonce, 64'h0);
    check("rst_drop", 64'(drop_count), 64'h0);

    for (int c = 0; c < W / 32; c++) work_in[c*32 +: 32] = 32'hA5A5_5A5A ^ 32'(c);
    work_valid = 1'b1; tick(); work_valid = 1'b0;
    check("load_work", core_work[63:0], 64'hA5A5_5A5B_A5A5_5A5A);
    check("load_nrst0", 64'(core_nrst), 64'h0);
    for (int k = 1; k < RSTC; k++) begin tick(); check("load_nrst", 64'(core_nrst), 64'h0); end
    tick();
    check("run_nrst", 64'(core_nrst), 64'hF);
    check("run_active", 64'(work_active), 64'h1);

    for (int i = 0; i < N; i++) core_nonce[i*NW +: NW] = 64'h1000 + 64'(i);
    core_found = 4'hF; tick(); core_found = '0;
    repeat (4) tick();
    check("all4_valid", 64'(res_valid), 64'h1);
    check("all4_drop", 64'(drop_count), 64'h0);
    res_ready = 1'b1;
    for (int i = 0; i < N; i++) begin check("all4_order", res_nonce, 64'h1000 + 64'(i)); tick(); end
    check("all4_empty", 64'(res_valid), 64'h0);

    core_nonce[2*NW +: NW] = 64'h2000_0000_0000_0042;
    core_found = 4'b0100; tick(); core_found = '0;
    check("lat_t1", 64'(res_valid), 64'h0);
    tick();
    check("lat_t2", 64'(res_valid), 64'h1);
    check("lat_nonce", res_nonce, 64'h2000_0000_0000_0042);
    tick();
    check("lat_pop", 64'(res_valid), 64'h0);

    res_ready = 1'b0;
    for (int k = 0; k < 12; k++) begin
      core_nonce[NW-1:0] = 64'hC000 + 64'(k); core_found = 4'b0001; tick();
    end
    core_found = '0;
    check("ovf_drop", 64'(drop_count), 64'd3);
    check("ovf_head", res_nonce, 64'hC000);
    res_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin check("ovf_order", res_nonce, 64'hC000 + 64'(k)); tick(); end
    check("ovf_empty", 64'(res_valid), 64'h0);
    res_ready = 1'b0;

    core_found = 4'b0111; tick(); core_found = '0;
    repeat (3) tick();
    check("flush_pre", 64'(res_valid), 64'h1);
    work_valid = 1'b1; core_found = 4'hF; tick(); work_valid = 1'b0;
    check("flush_valid", 64'(res_valid), 64'h0);
    repeat (RSTC) tick();
    core_found = '0;
    check("flush_run", 64'(core_nrst), 64'hF);
    tick(); tick();
    check("flush_ignored", 64'(res_valid), 64'h0);
    check("flush_drop", 64'(drop_count), 64'd3);

    core_found = 4'b1010; tick(); core_found = '0;
    tick(); tick();
    check("mid_pre", 64'(res_valid), 64'h1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("mid_work", core_work[63:0], 64'h0);
    check("mid_valid", 64'(res_valid), 64'h0);
    check("mid_drop", 64'(drop_count), 64'h0);
    core_found = 4'hF; tick(); core_found = '0;
    tick(); tick();
    check("idle_nrst", 64'(core_nrst), 64'h0);
    check("idle_active", 64'(work_active), 64'h0);
    check("idle_valid", 64'(res_valid), 64'h0);

    for (int c = 0; c < W / 32; c++) work_in[c*32 +: 32] = $urandom;
    work_valid = 1'b1; tick(); work_valid = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst = ($urandom_range(0, 999) == 0);
      work_valid = !rst && ($urandom_range(0, 149) == 0);
      if (work_valid)
        for (int c = 0; c < W / 32; c++) work_in[c*32 +: 32] = $urandom;
      core_found = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      for (int i = 0; i < N; i++) core_nonce[i*NW +: NW] = {$urandom, $urandom};
      res_ready = ((cyc / 500) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
      tick();
    end
    rst = 1'b0; work_valid = 1'b0; core_found = '0; res_ready = 1'b1;
    tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
